// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM pulse generator.
// Imported by the interface, the counter and the top level.
package pwm_pkg;

  localparam int PWM_WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

endpackage

// File: rtl/pwm_pulse_generator_if.sv
// Control and waveform bundle for the PWM pulse generator.
// master drives the programming inputs, slave is the generator.
interface pwm_pulse_generator_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
);
  logic             enable;
  logic             one_shot;
  logic             start;
  logic [WIDTH-1:0] pulse_len_in;
  logic [WIDTH-1:0] period_len_in;
  logic             pwm;
  logic             busy;
  logic             period_done;

  modport master (
    output enable, one_shot, start,
    output pulse_len_in, period_len_in,
    input  pwm, busy, period_done
  );

  modport slave (
    input  enable, one_shot, start,
    input  pulse_len_in, period_len_in,
    output pwm, busy, period_done
  );
endinterface

// File: rtl/pwm_period_counter.sv
// Cycle counter for one PWM period with clear/increment.
// Flags the last cycle and whether the next cycle is still high.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] pulse_sh,
  input  logic [WIDTH-1:0] period_sh,
  output logic             last,
  output logic             hi_next
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   cnt_p1;

  // One extra bit so a period of 2^WIDTH-1 never wraps.
  always_comb begin
    cnt_p1  = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
    last    = (cnt_p1 == {1'b0, period_sh});
    hi_next = (cnt_p1 < {1'b0, pulse_sh});
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_p1[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pwm_pulse_generator.sv
// PWM generator: launch/reload FSM, shadow lengths, output flop.
// Lengths are only sampled at period boundaries so pwm never glitches.
module pwm_pulse_generator
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  pwm_pulse_generator_if.slave  bus
);
  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] pulse_sh_q, pulse_sh_d;
  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic             pwm_q, pwm_d;
  logic             launch_req, reload, load;
  logic             cnt_clr, cnt_inc;
  logic             last, hi_next;

  pwm_period_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .pulse_sh  (pulse_sh_q),
    .period_sh (period_sh_q),
    .last      (last),
    .hi_next   (hi_next)
  );

  always_comb begin
    launch_req = (bus.one_shot ? bus.start : bus.enable)
               && (bus.period_len_in != '0);
    reload     = (mode_q == MODE_CONT) && bus.enable
               && (bus.period_len_in != '0);
    state_d     = state_q;
    mode_d      = mode_q;
    pulse_sh_d  = pulse_sh_q;
    period_sh_d = period_sh_q;
    pwm_d       = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (launch_req) begin
          load    = 1'b1;
          state_d = ST_RUN;
          mode_d  = bus.one_shot ? MODE_ONESHOT : MODE_CONT;
        end
      end
      ST_RUN: begin
        if (last) begin
          if (reload) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          pwm_d = hi_next;
        end
      end
    endcase
    // Back-to-back reload: no dead cycle between periods.
    if (load) begin
      pulse_sh_d  = bus.pulse_len_in;
      period_sh_d = bus.period_len_in;
      pwm_d       = (bus.pulse_len_in != '0);
    end
    cnt_clr = load || ((state_q == ST_RUN) && last);
    cnt_inc = (state_q == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_CONT;
      pulse_sh_q  <= '0;
      period_sh_q <= '0;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pulse_sh_q  <= pulse_sh_d;
      period_sh_q <= period_sh_d;
      pwm_q       <= pwm_d;
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.period_done = (state_q == ST_RUN) && last;
endmodule
